// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Request FSM: IDLE may issue, WAIT expects a live response,
    // DROP swallows the response of a request killed by a redirect.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_e;

    // addi x0,x0,0 -- bubble presented to IF/ID when nothing is buffered.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Sequential fetch stride in bytes.
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_queue.sv
// Small {pc,inst} FIFO between the fetch engine and the IF/ID register.
// Flush has priority over push and pop.
module fetch_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned PC_W   = 64,
    parameter int unsigned INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [PC_W-1:0]          push_pc,
    input  logic [INST_W-1:0]        push_inst,
    output logic [PC_W-1:0]          head_pc,
    output logic [INST_W-1:0]        head_inst,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;

    // Pointer and occupancy bookkeeping; a flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues one-at-a-time word fetches, buffers the
// returned {pc,inst} pairs and presents the queue head to IF/ID.
module instr_fetch_unit #(
    parameter int unsigned        PC_W     = 64,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        DEPTH    = 2,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(fetch_pkg::NOP_INST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifid_write,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid
);
    import fetch_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   addr_q;
    logic              issue;
    logic              push;
    logic              pop;
    logic              q_empty;
    logic              q_full;
    logic [CW-1:0]     q_count;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;

    // Issue only happens from IDLE, where no response is owed, so the room
    // check reduces to count < DEPTH.
    assign issue = (state == IDLE) && !redirect && (32'(q_count) < DEPTH);
    assign push  = (state == WAIT) && imem_valid && !redirect;
    assign pop   = ifid_write && !q_empty && !redirect;

    // Request FSM, PC register and fetch-address capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            imem_req <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            if (redirect)   pc_q <= redirect_pc;
            else if (issue) pc_q <= pc_q + PC_W'(PC_INC);
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= WAIT;
                        imem_req <= 1'b1;
                        addr_q   <= pc_q;
                    end
                end
                WAIT: begin
                    // A redirect that coincides with the response consumes it,
                    // so there is nothing left to drop.
                    if (redirect)        state <= imem_valid ? IDLE : DROP;
                    else if (imem_valid) state <= IDLE;
                end
                DROP: begin
                    if (imem_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .push_pc   (addr_q),
        .push_inst (imem_rdata),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    // Room is reserved at issue time, so a response never lands on a full queue.
    assert property (@(posedge clk) disable iff (!reset) !(push && q_full && !pop));

    assign imem_addr = addr_q;
    assign if_valid  = !q_empty;
    assign if_pc     = q_empty ? pc_q : head_pc;
    assign if_inst   = q_empty ? NOP_INST : head_inst;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a transaction-level
// model: a list of buffered {pc,inst}, a next-PC, and an outstanding-request flag.
module tb_instr_fetch_unit;
    localparam int          PC_W     = 64;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ifid_write = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ifid_write  (ifid_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    // Reference model state
    entry_t      q[$];
    logic [63:0] pc_m;
    bit          busy;
    bit          stale;
    bit          exp_req;
    logic [63:0] exp_addr;
    logic [63:0] cur_addr;
    // Memory model state
    bit          pend;
    int          pend_cnt;
    int          lat;
    logic [63:0] pend_addr;
    logic [63:0] req_seen[$];
    bit          saw8;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory drives its response, model advances, DUT is checked after the edge.
    task automatic tick();
        bit busy_pre;
        int sz_pre;
        bit do_push;
        entry_t e;
        imem_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        exp_req = 1'b0;
        if (!reset) begin
            q.delete();
            busy  = 1'b0;
            stale = 1'b0;
            pc_m  = RESET_PC;
        end else begin
            busy_pre = busy;
            sz_pre   = q.size();
            do_push  = 1'b0;
            if (busy && imem_valid) begin
                do_push = !stale && !redirect;
                e.pc    = cur_addr;
                e.inst  = mem_word(cur_addr);
                busy    = 1'b0;
            end else if (busy && redirect) begin
                stale = 1'b1;
            end
            if (redirect) begin
                q.delete();
                pc_m = redirect_pc;
            end else begin
                if (ifid_write && sz_pre > 0) void'(q.pop_front());
                if (do_push) q.push_back(e);
                if (!busy_pre && sz_pre < DEPTH) begin
                    exp_req  = 1'b1;
                    exp_addr = pc_m;
                    cur_addr = pc_m;
                    pc_m     = pc_m + 64'd4;
                    busy     = 1'b1;
                    stale    = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, exp_addr);
        check("if_valid", if_valid, q.size() > 0);
        check("if_pc", if_pc, (q.size() > 0) ? q[0].pc : pc_m);
        check("if_inst", if_inst, (q.size() > 0) ? 64'(q[0].inst) : 64'(NOP));
        if (if_valid && if_pc == 64'h8) saw8 = 1'b1;
        if (imem_req) begin
            pend      = 1'b1;
            pend_cnt  = lat - 1;
            pend_addr = imem_addr;
            req_seen.push_back(imem_addr);
        end
        redirect = 1'b0;
    endtask

    task automatic do_reset(input bit keep_mem);
        reset = 1'b0;
        if (!keep_mem) pend = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bit          found;
        logic [63:0] a;
        n_checks = 0;
        n_fail   = 0;
        pend     = 1'b0;
        lat      = 1;
        busy     = 1'b0;
        stale    = 1'b0;
        pc_m     = RESET_PC;
        saw8     = 1'b0;

        // Reset state, then latency-1 streaming with IF/ID always capturing
        ifid_write = 1'b1;
        do_reset(1'b0);
        req_seen.delete();
        for (int i = 0; i < 9; i++) tick();
        check("t1_nreq", req_seen.size() >= 3, 1);
        a = (req_seen.size() > 2) ? req_seen[2] : 'x;
        check("t1_req2", a, 64'h8);
        a = (req_seen.size() > 1) ? req_seen[1] : 'x;
        check("t1_req1", a, 64'h4);

        // IF/ID stalled: queue fills with 0x0,0x4 and requests stop
        ifid_write = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("t2_head_pc", if_pc, 64'h0);
        check("t2_no_req", imem_req, 0);
        ifid_write = 1'b1;
        tick();
        check("t2_next_pc", if_pc, 64'h4);
        for (int i = 0; i < 6; i++) tick();

        // Redirect while waiting (latency 3) on 0x8
        do_reset(1'b0);
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (exp_req && exp_addr == 64'h8) found = 1'b1;
        end
        check("t3_reach8", found, 1);
        saw8 = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        check("t3_target", imem_addr, 64'h100);
        for (int i = 0; i < 8; i++) tick();
        check("t3_no_stale", saw8, 0);

        // Redirect coinciding with a response and a pop
        lat        = 1;
        ifid_write = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (exp_req) found = 1'b1;
        end
        check("t4_req", found, 1);
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        ifid_write  = 1'b1;
        tick();
        check("t4_valid", if_valid, 0);
        check("t4_inst", if_inst, 64'(NOP));
        check("t4_pc", if_pc, 64'h200);
        for (int i = 0; i < 4; i++) tick();

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (exp_req && exp_addr == 64'hFFFF_FFFF_FFFF_FFFC) found = 1'b1;
        end
        check("t5_top", found, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_req) found = 1'b1;
        end
        check("t5_wrap", imem_addr, 64'h0);

        // Reset with a request outstanding; its late response arrives while IDLE
        do_reset(1'b0);
        lat   = 4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (exp_req) found = 1'b1;
        end
        check("t6_req", found, 1);
        reset = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_first_req", imem_req, 1);
        check("t6_first_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 12; i++) tick();

        // Randomized stalls, latencies and redirects
        for (int i = 0; i < 400; i++) begin
            ifid_write = ($urandom_range(0, 3) != 0);
            lat        = $urandom_range(1, 4);
            if ($urandom_range(0, 11) == 0) begin
                redirect    = 1'b1;
                redirect_pc = {32'($urandom), 32'($urandom)} & ~64'h3;
            end
            tick();
        end
        ifid_write = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
